// File: rtl/simple_bus_pkg.sv
// Shared definitions for the simple peripheral bus master: state encoding,
// window and bus widths, and the address window decode helper.
package simple_bus_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned PADDR_W  = 16;
   localparam int unsigned WIN_W    = 18;
   localparam int unsigned CNT_W    = 4;
   localparam logic [DATA_W-1:0] BASE_DEFAULT = 32'h9000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_ACK,
      ST_ERR
   } state_t;

   // Only the bits above the window are compared, so any base within the
   // same 256 KB block decodes identically.
   function automatic logic in_window(input logic [DATA_W-1:0] adr,
                                      input logic [DATA_W-1:0] base);
      return adr[DATA_W-1:WIN_W] == base[DATA_W-1:WIN_W];
   endfunction

endpackage

// File: rtl/simple_bus_byte_merge.sv
// Combinational byte-lane merge: lanes selected by sel come from new_data,
// the remaining lanes keep old_data.
module simple_bus_byte_merge
   import simple_bus_pkg::*;
(
   input  logic [DATA_W-1:0]   old_data,
   input  logic [DATA_W-1:0]   new_data,
   input  logic [DATA_W/8-1:0] sel,
   output logic [DATA_W-1:0]   merged
);

   always_comb begin
      merged = old_data;
      for (int i = 0; i < DATA_W/8; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      end
   end

endmodule

// File: rtl/simple_bus_master.sv
// Wishbone classic slave that turns single cycles into peripheral register
// accesses, with read-modify-write for partial-byte writes.
module simple_bus_master
   import simple_bus_pkg::*;
#(
   parameter logic [DATA_W-1:0] BASE   = BASE_DEFAULT,
   parameter int unsigned       RD_LAT = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [DATA_W-1:0]     wb_adr_i,
   input  logic [DATA_W/8-1:0]   wb_sel_i,
   input  logic [DATA_W-1:0]     wb_dat_i,
   output logic [DATA_W-1:0]     wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  p_wea,
   output logic [PADDR_W-1:0]    p_addr,
   output logic [DATA_W-1:0]     p_din,
   input  logic [DATA_W-1:0]     p_dout
);

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rmw_q, rmw_d;
   logic [DATA_W/8-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0]     dat_q, dat_d;
   logic [DATA_W-1:0]     dat_o_d, p_din_d, merged;
   logic [PADDR_W-1:0]    p_addr_d;
   logic                  ack_d, err_d, wea_d;
   logic                  adr_unused;

   assign adr_unused = ^wb_adr_i[1:0];

   simple_bus_byte_merge u_merge (
      .old_data (p_dout),
      .new_data (dat_q),
      .sel      (sel_q),
      .merged   (merged)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rmw_q    <= 1'b0;
         sel_q    <= '0;
         dat_q    <= '0;
         wb_dat_o <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         p_wea    <= 1'b0;
         p_addr   <= '0;
         p_din    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rmw_q    <= rmw_d;
         sel_q    <= sel_d;
         dat_q    <= dat_d;
         wb_dat_o <= dat_o_d;
         wb_ack_o <= ack_d;
         wb_err_o <= err_d;
         p_wea    <= wea_d;
         p_addr   <= p_addr_d;
         p_din    <= p_din_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rmw_d    = rmw_q;
      sel_d    = sel_q;
      dat_d    = dat_q;
      dat_o_d  = wb_dat_o;
      p_addr_d = p_addr;
      p_din_d  = p_din;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      wea_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               p_addr_d = wb_adr_i[PADDR_W+1:2];
               sel_d    = wb_sel_i;
               dat_d    = wb_dat_i;
               cnt_d    = '0;
               rmw_d    = 1'b0;
               if (!in_window(wb_adr_i, BASE)) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else if (wb_sel_i == '0) begin
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
               end else if (!wb_we_i) begin
                  state_d = ST_READ;
               end else if (wb_sel_i == '1) begin
                  state_d = ST_WRITE;
                  p_din_d = wb_dat_i;
                  wea_d   = 1'b1;
               end else begin
                  state_d = ST_READ;
                  rmw_d   = 1'b1;
               end
            end
         end

         ST_READ: begin
            // Dropping cyc abandons the access; nothing is written or acked.
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               rmw_d   = 1'b0;
            end else if (cnt_q == RD_LAST) begin
               cnt_d = '0;
               if (rmw_q) begin
                  state_d = ST_WRITE;
                  p_din_d = merged;
                  wea_d   = 1'b1;
                  rmw_d   = 1'b0;
               end else begin
                  state_d = ST_ACK;
                  dat_o_d = p_dout;
                  ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // The strobe already went out; only the ack depends on cyc.
         ST_WRITE: begin
            state_d = ST_ACK;
            ack_d   = wb_cyc_i;
         end

         ST_ACK,
         ST_ERR:  state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_simple_bus_master.sv
// Directed bench for simple_bus_master: one instance with RD_LAT=1 and one
// with RD_LAT=4 share the bus inputs; each scenario checks one of them.
module tb_simple_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_i, p_dout;
   logic [3:0]  sel;

   logic [31:0] a_dat_o, a_p_din, b_dat_o, b_p_din;
   logic        a_ack, a_err, a_wea, b_ack, b_err, b_wea;
   logic [15:0] a_p_addr, b_p_addr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   simple_bus_master #(.BASE(32'h9000_0000), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
      .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(a_dat_o),
      .wb_ack_o(a_ack), .wb_err_o(a_err),
      .p_wea(a_wea), .p_addr(a_p_addr), .p_din(a_p_din), .p_dout(p_dout)
   );

   simple_bus_master #(.BASE(32'h9000_0000), .RD_LAT(4)) dut_b (
      .clk(clk), .rst(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
      .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(b_dat_o),
      .wb_ack_o(b_ack), .wb_err_o(b_err),
      .p_wea(b_wea), .p_addr(b_p_addr), .p_din(b_p_din), .p_dout(p_dout)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 ns after the edge, once the registers settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
   endtask

   task automatic release_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      release_bus();
      adr = '0; sel = '0; dat_i = '0; p_dout = '0;
      @(negedge clk);
      do_reset();

      check("rst_ack",   32'(a_ack),    32'h0);
      check("rst_err",   32'(a_err),    32'h0);
      check("rst_wea",   32'(a_wea),    32'h0);
      check("rst_paddr", 32'(a_p_addr), 32'h0);
      check("rst_pdin",  a_p_din,       32'h0);
      check("rst_dato",  a_dat_o,       32'h0);

      // Full write at the top of the window
      request(1'b1, 32'h9003_FFFC, 4'hF, 32'h0000_A5A5);
      tick();
      check("fw_c1_wea",   32'(a_wea),    32'h1);
      check("fw_c1_paddr", 32'(a_p_addr), 32'h0000_FFFF);
      check("fw_c1_pdin",  a_p_din,       32'h0000_A5A5);
      check("fw_c1_ack",   32'(a_ack),    32'h0);
      tick();
      check("fw_c2_ack",   32'(a_ack),    32'h1);
      check("fw_c2_wea",   32'(a_wea),    32'h0);
      release_bus();
      tick();
      check("fw_c3_ack",   32'(a_ack),    32'h0);

      // Plain read
      p_dout = 32'h1234_5678;
      request(1'b0, 32'h9000_0010, 4'hF, 32'h0);
      tick();
      check("rd_c1_paddr", 32'(a_p_addr), 32'h0000_0004);
      check("rd_c1_ack",   32'(a_ack),    32'h0);
      check("rd_c1_wea",   32'(a_wea),    32'h0);
      tick();
      check("rd_c2_ack",   32'(a_ack),    32'h1);
      check("rd_c2_dato",  a_dat_o,       32'h1234_5678);
      check("rd_c2_wea",   32'(a_wea),    32'h0);
      release_bus();
      tick();

      // Partial write via read-modify-write
      p_dout = 32'h1111_2222;
      request(1'b1, 32'h9000_0020, 4'b0011, 32'hDEAD_BEEF);
      tick();
      check("rmw_c1_wea",  32'(a_wea),    32'h0);
      check("rmw_c1_ack",  32'(a_ack),    32'h0);
      tick();
      check("rmw_c2_wea",  32'(a_wea),    32'h1);
      check("rmw_c2_pdin", a_p_din,       32'h1111_BEEF);
      check("rmw_c2_ack",  32'(a_ack),    32'h0);
      check("rmw_c2_dato", a_dat_o,       32'h1234_5678);
      tick();
      check("rmw_c3_ack",  32'(a_ack),    32'h1);
      check("rmw_c3_wea",  32'(a_wea),    32'h0);
      release_bus();
      tick();

      // Out-of-window access
      request(1'b1, 32'h8000_0000, 4'hF, 32'h0);
      tick();
      check("oow_c1_err",  32'(a_err),    32'h1);
      check("oow_c1_ack",  32'(a_ack),    32'h0);
      check("oow_c1_wea",  32'(a_wea),    32'h0);
      release_bus();
      tick();
      check("oow_c2_err",  32'(a_err),    32'h0);
      check("oow_c2_ack",  32'(a_ack),    32'h0);
      check("oow_pdin_hold", a_p_din,     32'h1111_BEEF);

      // Empty byte select acks without a peripheral access
      request(1'b1, 32'h9000_0008, 4'h0, 32'hFFFF_FFFF);
      tick();
      check("sel0_c1_ack", 32'(a_ack),    32'h1);
      check("sel0_c1_wea", 32'(a_wea),    32'h0);
      release_bus();
      tick();
      check("sel0_c2_ack", 32'(a_ack),    32'h0);

      // Back-to-back full writes
      request(1'b1, 32'h9000_0000, 4'hF, 32'h0000_0001);
      tick();
      check("b2b_c1_wea",  32'(a_wea),    32'h1);
      check("b2b_c1_pdin", a_p_din,       32'h0000_0001);
      tick();
      check("b2b_c2_ack",  32'(a_ack),    32'h1);
      check("b2b_c2_wea",  32'(a_wea),    32'h0);
      release_bus();
      tick();
      check("b2b_c3_wea",  32'(a_wea),    32'h0);
      check("b2b_c3_ack",  32'(a_ack),    32'h0);
      request(1'b1, 32'h9000_0004, 4'hF, 32'h0000_0002);
      tick();
      check("b2b_c4_wea",  32'(a_wea),    32'h1);
      check("b2b_c4_pdin", a_p_din,       32'h0000_0002);
      check("b2b_c4_paddr", 32'(a_p_addr), 32'h0000_0001);
      tick();
      check("b2b_c5_ack",  32'(a_ack),    32'h1);
      check("b2b_c5_wea",  32'(a_wea),    32'h0);
      release_bus();
      tick();
      check("b2b_c6_ack",  32'(a_ack),    32'h0);

      // RD_LAT=4: read aborted by dropping cyc in cycle 2
      do_reset();
      p_dout = 32'hCAFE_F00D;
      request(1'b0, 32'h9000_0040, 4'hF, 32'h0);
      tick();
      check("abt_c1_ack",  32'(b_ack),    32'h0);
      tick();
      check("abt_c2_ack",  32'(b_ack),    32'h0);
      release_bus();
      tick();
      check("abt_c3_ack",  32'(b_ack),    32'h0);
      check("abt_c3_wea",  32'(b_wea),    32'h0);
      check("abt_c3_dato", b_dat_o,       32'h0);
      // Accepted at this edge only if the block is back in IDLE
      request(1'b1, 32'h9000_0000, 4'h0, 32'h0);
      tick();
      check("abt_idle_ack", 32'(b_ack),   32'h1);
      release_bus();
      tick();

      // RD_LAT=4: full read, ack in cycle 5
      p_dout = 32'h0BAD_F00D;
      request(1'b0, 32'h9000_0044, 4'hF, 32'h0);
      tick();
      tick();
      tick();
      tick();
      check("lat4_c4_ack",  32'(b_ack),   32'h0);
      check("lat4_paddr",   32'(b_p_addr), 32'h0000_0011);
      tick();
      check("lat4_c5_ack",  32'(b_ack),   32'h1);
      check("lat4_c5_dato", b_dat_o,      32'h0BAD_F00D);
      release_bus();
      tick();

      // Reset while in WRITE
      request(1'b1, 32'h9000_0010, 4'hF, 32'h0000_55AA);
      tick();
      check("rstw_c1_wea",  32'(a_wea),   32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw_wea",   32'(a_wea),     32'h0);
      check("rstw_ack",   32'(a_ack),     32'h0);
      check("rstw_err",   32'(a_err),     32'h0);
      check("rstw_paddr", 32'(a_p_addr),  32'h0);
      check("rstw_pdin",  a_p_din,        32'h0);
      check("rstw_dato",  a_dat_o,        32'h0);
      release_bus();
      tick();
      check("rstw_after_ack", 32'(a_ack), 32'h0);
      check("rstw_after_wea", 32'(a_wea), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
